fp_mul_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754-style floating-point multiplier; next generation of the combinational single-precision multiplier.
- Format is set by the exponent and mantissa widths; default is binary32.
- Adds a 3-stage pipeline, valid/ready handshake with backpressure, special-value handling (zero/inf/NaN) and selectable rounding.
- Sits between operand-issue logic and result consumers in the arithmetic datapath.

---
 rtl/fp_mul_pipe_if.sv | 29 ++
 rtl/fp_mul_pipe.sv | 155 +++++++++++++++
 tb/tb_fp_mul_pipe.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pipe_if.sv
// fp_mul_pipe_if: operand/result valid-ready bus for fp_mul_pipe.
// master = operand issuer / result consumer side, slave = the multiplier.
interface fp_mul_pipe_if #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
);
   localparam int unsigned W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] f_prod;
   logic         u_flow;
   logic         o_flow;
   logic         invalid;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, f_prod, u_flow, o_flow, invalid
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, f_prod, u_flow, o_flow, invalid
   );
endinterface

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier with valid/ready backpressure.
// Rounding is truncation by default; define FP_MUL_ROUND_NEAREST_EN for round-to-nearest-even.
module fp_mul_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic         clk,
   input  logic         rst,
   fp_mul_pipe_if.slave bus
);
   localparam int unsigned W     = 1 + EXP_W + MAN_W;
   localparam int unsigned SIG_W = MAN_W + 1;
   localparam int unsigned P_W   = 2 * SIG_W;
   localparam int unsigned E_W   = EXP_W + 2;
`ifdef FP_MUL_ROUND_NEAREST_EN
   localparam int unsigned P_T   = P_W;
   localparam int unsigned MC_W  = MAN_W + 1;
`else
   localparam int unsigned P_T   = MAN_W + 2;
`endif
   localparam logic [E_W-1:0] BIAS  = E_W'((2 ** (EXP_W - 1)) - 1);
   localparam logic [E_W-1:0] E_MAX = E_W'((2 ** EXP_W) - 1);
   localparam logic [W-1:0]   QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic             w_advance;
   logic [EXP_W-1:0] w_ea, w_eb;
   logic [MAN_W-1:0] w_ma, w_mb;
   logic             w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
   logic [P_T-1:0]   w_p;
   logic [E_W-1:0]   w_e;

   logic             r_v1, r_v2, r_v3;
   logic             r_sign1, r_inv1, r_inf1, r_zero1;
   logic [P_T-1:0]   r_p1;
   logic [E_W-1:0]   r_e1;
   logic             r_sign2, r_inv2, r_inf2, r_zero2;
   logic [MAN_W-1:0] r_man2;
   logic [E_W-1:0]   r_e2;
   logic [W-1:0]     r_f_prod;
   logic             r_u_flow, r_o_flow, r_invalid;

   logic             w_msb;
   logic [MAN_W-1:0] w_man, w_man_r;
   logic [E_W-1:0]   w_e_n, w_e_r;
`ifdef FP_MUL_ROUND_NEAREST_EN
   logic             w_guard, w_sticky, w_rnd_up, w_carry;
`endif
   logic [W-1:0]     w_f_prod;
   logic             w_u_flow, w_o_flow, w_invalid;

   // Whole pipe moves together; in_ready never looks at in_valid.
   assign w_advance    = ~r_v3 | bus.out_ready;
   assign bus.in_ready = w_advance;

   // S1: unpack, classify, significand product and biased exponent sum
   assign w_ea     = bus.a[W-2 -: EXP_W];
   assign w_eb     = bus.b[W-2 -: EXP_W];
   assign w_ma     = bus.a[MAN_W-1:0];
   assign w_mb     = bus.b[MAN_W-1:0];
   assign w_zero_a = (w_ea == '0);
   assign w_zero_b = (w_eb == '0);
   assign w_inf_a  = (w_ea == '1) && (w_ma == '0);
   assign w_inf_b  = (w_eb == '1) && (w_mb == '0);
   assign w_nan_a  = (w_ea == '1) && (w_ma != '0);
   assign w_nan_b  = (w_eb == '1) && (w_mb != '0);
   // Truncating build keeps only the product bits that can reach the mantissa.
   assign w_p      = P_T'((P_W'({1'b1, w_ma}) * P_W'({1'b1, w_mb})) >> (P_W - P_T));
   assign w_e      = E_W'(w_ea) + E_W'(w_eb) - BIAS;

   // S2: normalise and round
   always_comb begin
      w_msb = r_p1[P_T-1];
      w_man = w_msb ? r_p1[P_T-2 -: MAN_W] : r_p1[P_T-3 -: MAN_W];
      w_e_n = w_msb ? (r_e1 + E_W'(1)) : r_e1;
`ifdef FP_MUL_ROUND_NEAREST_EN
      w_guard  = w_msb ? r_p1[P_T-2-MAN_W] : r_p1[P_T-3-MAN_W];
      w_sticky = w_msb ? (|r_p1[P_T-3-MAN_W:0]) : (|r_p1[P_T-4-MAN_W:0]);
      w_rnd_up = w_guard & (w_sticky | w_man[0]);
      {w_carry, w_man_r} = {1'b0, w_man} + MC_W'(w_rnd_up);
      w_e_r = w_carry ? (w_e_n + E_W'(1)) : w_e_n;
`else
      w_man_r = w_man;
      w_e_r   = w_e_n;
`endif
   end

   // S3: pack with special-value priority
   always_comb begin
      w_f_prod  = {r_sign2, r_e2[EXP_W-1:0], r_man2};
      w_u_flow  = 1'b0;
      w_o_flow  = 1'b0;
      w_invalid = 1'b0;
      if (r_inv2) begin
         w_f_prod  = QNAN;
         w_invalid = 1'b1;
      end else if (r_inf2) begin
         w_f_prod = {r_sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (r_zero2) begin
         w_f_prod = {r_sign2, {(W-1){1'b0}}};
      end else if ($signed(r_e2) >= $signed(E_MAX)) begin
         w_f_prod = {r_sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_o_flow = 1'b1;
      end else if ($signed(r_e2) <= $signed(E_W'(0))) begin
         w_f_prod = {r_sign2, {(W-1){1'b0}}};
         w_u_flow = 1'b1;
      end
   end

   // Stage valids and result registers; results only load from a valid S2.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_v3      <= 1'b0;
         r_f_prod  <= '0;
         r_u_flow  <= 1'b0;
         r_o_flow  <= 1'b0;
         r_invalid <= 1'b0;
      end else if (w_advance) begin
         r_v1 <= bus.in_valid;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         if (r_v2) begin
            r_f_prod  <= w_f_prod;
            r_u_flow  <= w_u_flow;
            r_o_flow  <= w_o_flow;
            r_invalid <= w_invalid;
         end
      end
   end

   // Datapath registers; content of bubble stages is don't-care.
   always_ff @(posedge clk) begin
      if (w_advance) begin
         r_sign1 <= bus.a[W-1] ^ bus.b[W-1];
         r_inv1  <= w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b);
         r_inf1  <= w_inf_a | w_inf_b;
         r_zero1 <= w_zero_a | w_zero_b;
         r_p1    <= w_p;
         r_e1    <= w_e;
         r_sign2 <= r_sign1;
         r_inv2  <= r_inv1;
         r_inf2  <= r_inf1;
         r_zero2 <= r_zero1;
         r_man2  <= w_man_r;
         r_e2    <= w_e_r;
      end
   end

   assign bus.out_valid = r_v3;
   assign bus.f_prod    = r_f_prod;
   assign bus.u_flow    = r_u_flow;
   assign bus.o_flow    = r_o_flow;
   assign bus.invalid   = r_invalid;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed and randomized checks of fp_mul_pipe (binary32) against
// an arithmetic reference model and an in-order result queue.
module tb_fp_mul_pipe;
   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam int unsigned W     = 32;

   typedef struct packed {
      logic [W-1:0] p;
      logic         u;
      logic         o;
      logic         inv;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_pops  = 0;
   res_t exp_q[$];
   logic hold_pend = 1'b0;
   res_t hold_val;

   fp_mul_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus_if ();

   fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic res_t mk(input logic [31:0] p, input logic u, input logic o, input logic inv);
      res_t r;
      r.p   = p;
      r.u   = u;
      r.o   = o;
      r.inv = inv;
      return r;
   endfunction

   function automatic res_t dut_res();
      return {bus_if.f_prod, bus_if.u_flow, bus_if.o_flow, bus_if.invalid};
   endfunction

   // Reference: exact integer product, remainder-based rounding.
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
      res_t   r;
      logic   s;
      int     ea, eb, e, sh;
      longint sig_a, sig_b, p, q;
      logic   nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
`ifdef FP_MUL_ROUND_NEAREST_EN
      longint rem, half;
`endif
      r      = '0;
      s      = a[31] ^ b[31];
      ea     = int'(a[30:23]);
      eb     = int'(b[30:23]);
      zero_a = (ea == 0);
      zero_b = (eb == 0);
      inf_a  = (ea == 255) && (a[22:0] == 23'd0);
      inf_b  = (eb == 255) && (b[22:0] == 23'd0);
      nan_a  = (ea == 255) && (a[22:0] != 23'd0);
      nan_b  = (eb == 255) && (b[22:0] != 23'd0);
      if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
         r.p   = 32'h7FC00000;
         r.inv = 1'b1;
         return r;
      end
      if (inf_a || inf_b) begin
         r.p = {s, 8'hFF, 23'd0};
         return r;
      end
      if (zero_a || zero_b) begin
         r.p = {s, 31'd0};
         return r;
      end
      sig_a = longint'(a[22:0]) + (longint'(1) << 23);
      sig_b = longint'(b[22:0]) + (longint'(1) << 23);
      p     = sig_a * sig_b;
      e     = ea + eb - 127;
      if (p >= (longint'(1) << 47)) begin
         sh = 24;
         e  = e + 1;
      end else begin
         sh = 23;
      end
      q = p >> sh;
`ifdef FP_MUL_ROUND_NEAREST_EN
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
`endif
      if (e >= 255) begin
         r.p = {s, 8'hFF, 23'd0};
         r.o = 1'b1;
      end else if (e <= 0) begin
         r.p = {s, 31'd0};
         r.u = 1'b1;
      end else begin
         r.p = {s, 8'(e), q[22:0]};
      end
      return r;
   endfunction

   function automatic logic [31:0] rand_op();
      logic [7:0]  e;
      logic [22:0] m;
      case ($urandom_range(0, 7))
         0:       e = 8'd0;
         1:       e = 8'hFF;
         2:       e = 8'($urandom_range(1, 20));
         3:       e = 8'($urandom_range(230, 254));
         default: e = 8'($urandom_range(100, 154));
      endcase
      m = ($urandom_range(0, 5) == 0) ? 23'd0 : 23'($urandom);
      return {1'($urandom), e, m};
   endfunction

   // Compare process: in-order scoreboard, hold stability and in_ready rule.
   always @(negedge clk) begin
      res_t act;
      res_t e;
      act = dut_res();
      if (rst) begin
         exp_q.delete();
         hold_pend = 1'b0;
      end else begin
         check("in_ready_rule", 64'(bus_if.in_ready), 64'(!bus_if.out_valid || bus_if.out_ready));
         if (hold_pend) begin
            check("hold_valid", 64'(bus_if.out_valid), 64'd1);
            check("hold_data", 64'(act), 64'(hold_val));
         end
         hold_pend = 1'b0;
         if (bus_if.out_valid && !bus_if.out_ready) begin
            hold_pend = 1'b1;
            hold_val  = act;
         end
         if (bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_out: got %h with nothing outstanding", act);
            end else begin
               e = exp_q.pop_front();
               check("result", 64'(act), 64'(e));
               n_pops++;
            end
         end
         if (bus_if.in_valid && bus_if.in_ready)
            exp_q.push_back(model(bus_if.a, bus_if.b));
      end
   end

   task automatic single_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input res_t exp);
      check({name, "_model"}, 64'(model(a, b)), 64'(exp));
      @(posedge clk); #1;
      bus_if.in_valid  = 1'b1;
      bus_if.a         = a;
      bus_if.b         = b;
      bus_if.out_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      check({name, "_lat1"}, 64'(bus_if.out_valid), 64'd0);
      @(negedge clk);
      check({name, "_lat2"}, 64'(bus_if.out_valid), 64'd0);
      @(negedge clk);
      check({name, "_lat3"}, 64'(bus_if.out_valid), 64'd1);
      check(name, 64'(dut_res()), 64'(exp));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] bp_a [4];
      logic [31:0] bp_b [4];
      int          pops0;
      int          sent;
      int          guard;
      logic        acc;

      bus_if.in_valid  = 1'b0;
      bus_if.a         = '0;
      bus_if.b         = '0;
      bus_if.out_ready = 1'b1;
      rst              = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      check("rst_outputs", 64'(dut_res()), 64'd0);
      check("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      single_op("mul_1p5x2", 32'h3FC00000, 32'h40000000, mk(32'h40400000, 1'b0, 1'b0, 1'b0));
`ifdef FP_MUL_ROUND_NEAREST_EN
      single_op("round_tie", 32'h3F800001, 32'h3FC00000, mk(32'h3FC00002, 1'b0, 1'b0, 1'b0));
`else
      single_op("round_tie", 32'h3F800001, 32'h3FC00000, mk(32'h3FC00001, 1'b0, 1'b0, 1'b0));
`endif
      single_op("overflow", 32'h7F000000, 32'h7F000000, mk(32'h7F800000, 1'b0, 1'b1, 1'b0));
      single_op("underflow", 32'h00800000, 32'h80800000, mk(32'h80000000, 1'b1, 1'b0, 1'b0));
      single_op("inf_x_zero", 32'h7F800000, 32'h00000000, mk(32'h7FC00000, 1'b0, 1'b0, 1'b1));
      single_op("neg_inf_x2", 32'hFF800000, 32'h40000000, mk(32'hFF800000, 1'b0, 1'b0, 1'b0));

      // Backpressure: three in flight, then stall with a fourth waiting.
      bp_a = '{32'h40400000, 32'hC0A00000, 32'h3E800000, 32'h42C80000};
      bp_b = '{32'h40000000, 32'h3F000000, 32'hC1200000, 32'h3DCCCCCD};
      @(posedge clk); #1;
      pops0            = n_pops;
      bus_if.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus_if.in_valid = 1'b1;
         bus_if.a        = bp_a[i];
         bus_if.b        = bp_b[i];
         @(posedge clk); #1;
      end
      bus_if.out_ready = 1'b0;
      bus_if.a         = bp_a[3];
      bus_if.b         = bp_b[3];
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(bus_if.in_ready), 64'd0);
         check("bp_held", 64'(dut_res()), 64'(model(bp_a[0], bp_b[0])));
         @(posedge clk); #1;
      end
      bus_if.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_stream_valid", 64'(bus_if.out_valid), 64'd1);
         @(posedge clk); #1;
         bus_if.in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_drained", 64'(bus_if.out_valid), 64'd0);
      check("bp_pop_count", 64'(n_pops - pops0), 64'd4);
      check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset with two operations in flight.
      @(posedge clk); #1;
      bus_if.in_valid = 1'b1;
      bus_if.a        = 32'h40400000;
      bus_if.b        = 32'h40400000;
      @(posedge clk); #1;
      bus_if.a = 32'h3F800000;
      @(posedge clk); #1;
      bus_if.in_valid = 1'b0;
      rst             = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 64'(bus_if.out_valid), 64'd0);
      check("midrst_outputs", 64'(dut_res()), 64'd0);
      pops0 = n_pops;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("midrst_no_ghost", 64'(bus_if.out_valid), 64'd0);
      end
      check("midrst_pop_count", 64'(n_pops - pops0), 64'd0);
      single_op("after_rst", 32'h3FC00000, 32'h40000000, mk(32'h40400000, 1'b0, 1'b0, 1'b0));

      // Randomized traffic with random backpressure.
      @(posedge clk); #1;
      sent  = 0;
      guard = 0;
      while ((sent < 300) && (guard < 5000)) begin
         if (!bus_if.in_valid && ($urandom_range(0, 3) != 0)) begin
            bus_if.in_valid = 1'b1;
            bus_if.a        = rand_op();
            bus_if.b        = rand_op();
         end
         bus_if.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = bus_if.in_valid && bus_if.in_ready;
         @(posedge clk); #1;
         if (acc) begin
            sent++;
            bus_if.in_valid = 1'b0;
         end
         guard++;
      end
      check("rand_sent", 64'(sent), 64'd300);
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      guard            = 0;
      while ((exp_q.size() != 0) && (guard < 20)) begin
         @(posedge clk); #1;
         guard++;
      end
      @(negedge clk);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      check("final_out_valid", 64'(bus_if.out_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
